// File: rtl/instruction_fetch_register.sv
// rtl/instruction_fetch_register.sv - instruction register assembled from memory beats
//
// Builds an IR_W-bit instruction from IR_W/BUS_W beats of BUS_W bits each.
// A fetch FSM (IDLE/FETCH/DONE) accepts beats over a valid/ready handshake
// and counts them. A direct chunk-write path lets control logic load a
// single chunk outside of a fetch.
//
// Optional feature macro: IR_PARITY_EN (adds IParity / ParityErr).
//
// Ports:
//   Clock     in   1      rising-edge clock
//   Reset     in   1      asynchronous active-low reset
//   Start     in   1      request a fetch of a new instruction
//   I         in   BUS_W  beat data / direct-write data
//   IValid    in   1      beat on I is valid
//   IReady    out  1      beat accepted this cycle when IValid is high (FETCH)
//   Write     in   1      direct chunk write enable (IDLE/DONE only)
//   Sel       in   SEL_W  chunk index for a direct write
//   IROut     out  IR_W   assembled instruction
//   IRValid   out  1      IROut holds a complete fetched instruction
//   Busy      out  1      fetch in progress
//   IParity   in   1      even-parity bit of I        (IR_PARITY_EN)
//   ParityErr out  1      sticky beat parity error    (IR_PARITY_EN)
module instruction_fetch_register #(
    parameter int BUS_W     = 8,
    parameter int IR_W      = 16,
    parameter bit MSB_FIRST = 1'b1,
    localparam int BEATS    = IR_W / BUS_W,
    localparam int SEL_W    = (BEATS > 2) ? $clog2(BEATS) : 1
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic [BUS_W-1:0]  I,
    input  logic              IValid,
    output logic              IReady,
    input  logic              Write,
    input  logic [SEL_W-1:0]  Sel,
    output logic [IR_W-1:0]   IROut,
    output logic              IRValid,
`ifdef IR_PARITY_EN
    input  logic              IParity,
    output logic              ParityErr,
`endif
    output logic              Busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state;
    logic [SEL_W-1:0] beat_cnt;
    logic [IR_W-1:0]  ir;
    logic             ir_valid;
    logic             fetch_beat;
    logic             direct_ok;
    logic             last_beat;
    logic [BEATS-1:0] fetch_we;
    logic [BEATS-1:0] direct_we;

    assign IReady  = (state == FETCH);
    assign Busy    = (state == FETCH);
    assign IROut   = ir;
    assign IRValid = ir_valid;

    assign fetch_beat = (state == FETCH) && IValid;
    // Start has priority over Write; writes are only honoured while not fetching.
    assign direct_ok  = Write && !Start && ((state == IDLE) || (state == DONE));
    assign last_beat  = (beat_cnt == SEL_W'(BEATS - 1));

    // Per-chunk write enables. Beat n lands in chunk BEATS-1-n (MSB first)
    // or chunk n. An out-of-range Sel matches no chunk, so it writes nothing.
    always_comb begin
        fetch_we  = '0;
        direct_we = '0;
        for (int k = 0; k < BEATS; k++) begin
            fetch_we[k]  = fetch_beat &&
                           (beat_cnt == SEL_W'(MSB_FIRST ? (BEATS - 1 - k) : k));
            direct_we[k] = direct_ok && (Sel == SEL_W'(k));
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            beat_cnt  <= '0;
            ir        <= '0;
            ir_valid  <= 1'b0;
`ifdef IR_PARITY_EN
            ParityErr <= 1'b0;
`endif
        end else begin
            for (int k = 0; k < BEATS; k++) begin
                if (fetch_we[k] || direct_we[k]) begin
                    ir[k*BUS_W +: BUS_W] <= I;
                end
            end

            case (state)
                IDLE, DONE: begin
                    if (Start) begin
                        state     <= FETCH;
                        beat_cnt  <= '0;
                        ir_valid  <= 1'b0;
`ifdef IR_PARITY_EN
                        ParityErr <= 1'b0;
`endif
                    end else if (|direct_we) begin
                        // Instruction was modified by hand; it is no longer a fetched one.
                        ir_valid <= 1'b0;
                    end
                end
                FETCH: begin
                    if (IValid) begin
                        if (last_beat) begin
                            state    <= DONE;
                            ir_valid <= 1'b1;
                        end else begin
                            beat_cnt <= beat_cnt + SEL_W'(1);
                        end
`ifdef IR_PARITY_EN
                        if ((^I) != IParity) begin
                            ParityErr <= 1'b1;
                        end
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_register.sv
// tb/tb_instruction_fetch_register.sv - directed scoreboard bench for instruction_fetch_register
module tb_instruction_fetch_register;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic [7:0]  I = '0;
    logic        IValid = 1'b0;
    logic        iparity = 1'b0;

    // dut_a: 16-bit MSB first (default)
    logic        start_a = 1'b0, write_a = 1'b0;
    logic [0:0]  sel_a = '0;
    logic        ready_a, valid_a, busy_a;
    logic [15:0] ir_a;
    // dut_b: 32-bit LSB first
    logic        start_b = 1'b0, write_b = 1'b0;
    logic        ready_b, valid_b, busy_b;
    logic [31:0] ir_b;
    // dut_c: 24-bit MSB first (three beats, Sel range has a hole)
    logic        start_c = 1'b0, write_c = 1'b0;
    logic [1:0]  sel2 = '0;
    logic        ready_c, valid_c, busy_c;
    logic [23:0] ir_c;
`ifdef IR_PARITY_EN
    logic        perr_a, perr_b, perr_c;
`endif

    int total = 0;
    int bad = 0;
    logic [31:0] exp_q[$];

    always #5 Clock = ~Clock;

    instruction_fetch_register #(.BUS_W(8), .IR_W(16), .MSB_FIRST(1'b1)) dut_a (
        .Clock(Clock), .Reset(Reset), .Start(start_a), .I(I), .IValid(IValid),
        .IReady(ready_a), .Write(write_a), .Sel(sel_a), .IROut(ir_a), .IRValid(valid_a),
`ifdef IR_PARITY_EN
        .IParity(iparity), .ParityErr(perr_a),
`endif
        .Busy(busy_a));

    instruction_fetch_register #(.BUS_W(8), .IR_W(32), .MSB_FIRST(1'b0)) dut_b (
        .Clock(Clock), .Reset(Reset), .Start(start_b), .I(I), .IValid(IValid),
        .IReady(ready_b), .Write(write_b), .Sel(sel2), .IROut(ir_b), .IRValid(valid_b),
`ifdef IR_PARITY_EN
        .IParity(iparity), .ParityErr(perr_b),
`endif
        .Busy(busy_b));

    instruction_fetch_register #(.BUS_W(8), .IR_W(24), .MSB_FIRST(1'b1)) dut_c (
        .Clock(Clock), .Reset(Reset), .Start(start_c), .I(I), .IValid(IValid),
        .IReady(ready_c), .Write(write_c), .Sel(sel2), .IROut(ir_c), .IRValid(valid_c),
`ifdef IR_PARITY_EN
        .IParity(iparity), .ParityErr(perr_c),
`endif
        .Busy(busy_c));

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic beat(input logic [7:0] d);
        I = d;
        IValid = 1'b1;
        step();
        IValid = 1'b0;
    endtask

    // Pops the oldest expected instruction and compares it to what the DUT shows.
    task automatic pop_chk(input string tag, input logic [31:0] obs);
        if (exp_q.size() == 0) begin
            chk({tag, "_queue_empty"}, 32'd0, 32'd1);
        end else begin
            chk(tag, obs, exp_q.pop_front());
        end
    endtask

    initial begin
        repeat (2) @(posedge Clock);
        #1;
        chk("rst_irout", ir_a, 0);
        chk("rst_irvalid", valid_a, 0);
        chk("rst_iready", ready_a, 0);
        chk("rst_busy", busy_a, 0);
        Reset = 1'b1;
        step();

        // Back-to-back beats, MSB first
        exp_q.push_back(32'h0000A53C);
        start_a = 1'b1; step(); start_a = 1'b0;
        chk("fetch_busy", busy_a, 1);
        chk("fetch_iready", ready_a, 1);
        beat(8'hA5);
        chk("partial_irout", ir_a, 16'hA500);
        chk("partial_irvalid", valid_a, 0);
        beat(8'h3C);
        chk("done_irvalid", valid_a, 1);
        chk("done_busy", busy_a, 0);
        pop_chk("fetch_a53c", ir_a);
        step();
        chk("done_hold", ir_a, 16'hA53C);

        // Direct write in DONE clears IRValid
        write_a = 1'b1; sel_a = 1'b0; I = 8'hFF; step(); write_a = 1'b0;
        chk("dwrite_irout", ir_a, 16'hA5FF);
        chk("dwrite_irvalid", valid_a, 0);
        chk("dwrite_busy", busy_a, 0);

        // Start and Write together: Start wins, no write
        start_a = 1'b1; write_a = 1'b1; sel_a = 1'b1; I = 8'h00; step();
        start_a = 1'b0; write_a = 1'b0;
        chk("startwrite_busy", busy_a, 1);
        chk("startwrite_irout", ir_a, 16'hA5FF);

        // Start during FETCH is ignored; the beat count keeps going
        exp_q.push_back(32'h00001122);
        beat(8'h11);
        start_a = 1'b1; step(); start_a = 1'b0;
        chk("restart_busy", busy_a, 1);
        beat(8'h22);
        chk("restart_irvalid", valid_a, 1);
        pop_chk("restart_1122", ir_a);

        // Stalled fetch: no change while IValid is low
        exp_q.push_back(32'h00001234);
        start_a = 1'b1; step(); start_a = 1'b0;
        beat(8'h12);
        for (int s = 0; s < 3; s++) begin
            step();
            chk("stall_irout", ir_a, 16'h1222);
            chk("stall_irvalid", valid_a, 0);
        end
        beat(8'h34);
        chk("stall_done_irvalid", valid_a, 1);
        pop_chk("stall_1234", ir_a);

        // 32-bit LSB-first fetch
        exp_q.push_back(32'h44332211);
        start_b = 1'b1; step(); start_b = 1'b0;
        beat(8'h11); beat(8'h22); beat(8'h33);
        chk("lsb_partial_irvalid", valid_b, 0);
        chk("lsb_partial_irout", ir_b, 32'h00332211);
        beat(8'h44);
        chk("lsb_irvalid", valid_b, 1);
        pop_chk("lsb_44332211", ir_b);

        // 24-bit: out-of-range Sel has no effect, in-range write does
        exp_q.push_back(32'h00010203);
        start_c = 1'b1; step(); start_c = 1'b0;
        beat(8'h01); beat(8'h02); beat(8'h03);
        chk("c_irvalid", valid_c, 1);
        pop_chk("c_010203", ir_c);
        write_c = 1'b1; sel2 = 2'd3; I = 8'h77; step(); write_c = 1'b0;
        chk("sel_oob_irout", ir_c, 24'h010203);
        chk("sel_oob_irvalid", valid_c, 1);
        write_c = 1'b1; sel2 = 2'd2; I = 8'hAA; step(); write_c = 1'b0;
        chk("sel2_irout", ir_c, 24'hAA0203);
        chk("sel2_irvalid", valid_c, 0);

        // Async reset with IROut=BEEF
        write_a = 1'b1; sel_a = 1'b1; I = 8'hBE; step();
        sel_a = 1'b0; I = 8'hEF; step(); write_a = 1'b0;
        chk("beef_irout", ir_a, 16'hBEEF);
        #2 Reset = 1'b0;
        #1;
        chk("async_rst_irout", ir_a, 0);
        chk("async_rst_irvalid", valid_a, 0);
        chk("async_rst_iready", ready_a, 0);
        chk("async_rst_busy", busy_a, 0);
        step();
        Reset = 1'b1;
        step();

        // Reset mid-fetch discards the partial instruction
        start_a = 1'b1; step(); start_a = 1'b0;
        beat(8'h99);
        chk("midfetch_irout", ir_a, 16'h9900);
        Reset = 1'b0;
        #1;
        chk("midrst_irout", ir_a, 0);
        chk("midrst_busy", busy_a, 0);
        step();
        Reset = 1'b1;
        step();

`ifdef IR_PARITY_EN
        start_a = 1'b1; step(); start_a = 1'b0;
        iparity = 1'b0; beat(8'h01);
        chk("perr_set", perr_a, 1);
        iparity = 1'b1; beat(8'h02);
        chk("perr_irvalid", valid_a, 1);
        chk("perr_sticky", perr_a, 1);
        step();
        chk("perr_done_hold", perr_a, 1);
        start_a = 1'b1; step(); start_a = 1'b0;
        chk("perr_clr_start", perr_a, 0);
        iparity = 1'b1; beat(8'h01);
        chk("perr_good_beat", perr_a, 0);
        Reset = 1'b0;
        #1;
        chk("perr_rst_irout", ir_a, 0);
        chk("perr_rst_busy", busy_a, 0);
        step();
        Reset = 1'b1;
        step();
`endif

        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
